// File: rtl/ram_ss_bridge.sv
// Savestate bridge: muxes a 64-bit-beat savestate bus onto a byte-enabled RAM
// shared with a core port, stalling the core while the savestate bus owns it.
module ram_ss_bridge #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned WIDTHAD      = 10,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTHAD-1:0]   core_addr,
    input  logic [WIDTH-1:0]     core_data,
    input  logic [WIDTH/8-1:0]   core_be,
    input  logic                 core_we,
    output logic                 core_stall,
    output logic [WIDTHAD-1:0]   ram_addr,
    output logic [WIDTH-1:0]     ram_data,
    output logic [WIDTH/8-1:0]   ram_be,
    output logic                 ram_we,
    input  logic [WIDTH-1:0]     ram_q,
    input  logic                 ss_sel,
    input  logic                 ss_read,
    input  logic                 ss_write,
    input  logic [31:0]          ss_addr,
    input  logic [63:0]          ss_data,
    output logic                 ss_ack,
    output logic [63:0]          ss_q,
    output logic [31:0]          ss_size,
    output logic [1:0]           ss_width
);

    localparam int unsigned NB    = WIDTH / 8;
    localparam int unsigned BW    = (WIDTH > 64) ? 64 : WIDTH;
    localparam int unsigned BL    = BW / 8;
    localparam int unsigned BEATS = WIDTH / BW;
    localparam int unsigned BB    = $clog2(BEATS);
    localparam int unsigned BBW   = (BB == 0) ? 1 : BB;
    localparam int unsigned CW    = 2;
    localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_HOLD
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       cnt;
    logic                ack_set;
    logic                q_load;
    logic                cnt_load;
    logic [BBW-1:0]      beat;
    logic [WIDTHAD-1:0]  word_addr;
    logic [WIDTH-1:0]    ss_wdata;
    logic [NB-1:0]       ss_be;
    logic [BW-1:0]       beat_q;
    logic                unused_ss;

    assign ss_size   = 32'(BEATS) << WIDTHAD;
    assign ss_width  = 2'($clog2(BL));
    assign word_addr = ss_addr[BB +: WIDTHAD];
    assign ss_wdata  = {BEATS{ss_data[BW-1:0]}};
    assign unused_ss = ^{ss_addr, ss_data};

    generate
        if (BB == 0) begin : g_single_beat
            assign beat = '0;
        end else begin : g_multi_beat
            assign beat = ss_addr[BBW-1:0];
        end
    endgenerate

    // Per-beat lane enables and read-beat select
    always_comb begin
        ss_be  = '0;
        beat_q = '0;
        for (int j = 0; j < int'(BEATS); j++) begin
            if (beat == BBW'(j)) begin
                ss_be[j*BL +: BL] = '1;
                beat_q            = ram_q[j*BW +: BW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (ss_sel && ss_write) begin
                    state_next = S_HOLD;
                end else if (ss_sel && ss_read) begin
                    state_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (!ss_sel) begin
                    state_next = S_IDLE;
                end else if (cnt == '0) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                // One access per request: wait for the master to drop it
                if (!ss_sel || (!ss_read && !ss_write)) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        core_stall = ss_sel;
        ram_addr   = core_addr;
        ram_data   = core_data;
        ram_be     = core_be;
        ram_we     = core_we;
        ack_set    = 1'b0;
        q_load     = 1'b0;
        cnt_load   = 1'b0;
        if (ss_sel) begin
            ram_addr = word_addr;
            ram_data = ss_wdata;
            ram_be   = ss_be;
            ram_we   = ss_write && (state == S_IDLE);
        end
        case (state)
            S_IDLE: begin
                if (ss_sel && ss_write) begin
                    ack_set = 1'b1;
                end else if (ss_sel && ss_read) begin
                    cnt_load = 1'b1;
                end
            end
            S_RD_WAIT: begin
                if (ss_sel && (cnt == '0)) begin
                    ack_set = 1'b1;
                    q_load  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Ack pulse, read-beat capture and read-latency countdown
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_ack <= 1'b0;
            ss_q   <= '0;
            cnt    <= '0;
        end else begin
            ss_ack <= ack_set;
            if (q_load) begin
                ss_q <= 64'(beat_q);
            end
            if (cnt_load) begin
                cnt <= CNT_INIT;
            end else if ((state == S_RD_WAIT) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ram_ss_bridge.sv
// Directed bench for ram_ss_bridge at WIDTH=128, READ_LATENCY=2 with a
// byte-enabled RAM model of matching latency.
module tb_ram_ss_bridge;

    localparam int unsigned W  = 128;
    localparam int unsigned AW = 10;
    localparam int unsigned L  = 2;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [63:0] data;
        logic [9:0]  exp_waddr;
        logic [15:0] exp_be;
        logic [63:0] exp_q;
        int          exp_lat;
        int          hold;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [AW-1:0]  core_addr;
    logic [W-1:0]   core_data;
    logic [W/8-1:0] core_be;
    logic           core_we;
    logic           core_stall;
    logic [AW-1:0]  ram_addr;
    logic [W-1:0]   ram_data;
    logic [W/8-1:0] ram_be;
    logic           ram_we;
    logic [W-1:0]   ram_q;
    logic           ss_sel;
    logic           ss_read;
    logic           ss_write;
    logic [31:0]    ss_addr;
    logic [63:0]    ss_data;
    logic           ss_ack;
    logic [63:0]    ss_q;
    logic [31:0]    ss_size;
    logic [1:0]     ss_width;

    int n_chk = 0;
    int n_err = 0;
    int ack_cnt = 0;
    int we_cnt = 0;

    logic [W-1:0] mem [1024] = '{default: '0};
    logic [W-1:0] pipe [L];

    ram_ss_bridge #(.WIDTH(W), .WIDTHAD(AW), .READ_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .core_addr(core_addr), .core_data(core_data), .core_be(core_be),
        .core_we(core_we), .core_stall(core_stall),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_be(ram_be),
        .ram_we(ram_we), .ram_q(ram_q),
        .ss_sel(ss_sel), .ss_read(ss_read), .ss_write(ss_write),
        .ss_addr(ss_addr), .ss_data(ss_data), .ss_ack(ss_ack), .ss_q(ss_q),
        .ss_size(ss_size), .ss_width(ss_width)
    );

    always #5 clk = ~clk;

    // RAM model: byte-enabled write, L-cycle registered read
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < int'(W / 8); b++) begin
                if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
            end
        end
        pipe[0] <= mem[ram_addr];
        for (int k = 1; k < int'(L); k++) pipe[k] <= pipe[k-1];
    end
    assign ram_q = pipe[L-1];

    always @(posedge clk) begin
        if (ss_ack) ack_cnt <= ack_cnt + 1;
        if (ram_we) we_cnt <= we_cnt + 1;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  a0, w0, lat;
        bit  got;
        string tag;
        tag = $sformatf("v%0d", idx);
        a0 = ack_cnt;
        w0 = we_cnt;
        @(negedge clk);
        ss_sel = 1'b1; ss_read = v.rd; ss_write = v.wr;
        ss_addr = v.addr; ss_data = v.data;
        core_we = 1'b1; core_addr = 10'd999; core_data = '1; core_be = '1;
        #1;
        chk({tag, " core_stall"}, 128'(core_stall), 128'(1));
        chk({tag, " ram_addr"}, 128'(ram_addr), 128'(v.exp_waddr));
        if (v.wr) begin
            chk({tag, " ram_we"}, 128'(ram_we), 128'(1));
            chk({tag, " ram_be"}, 128'(ram_be), 128'(v.exp_be));
            chk({tag, " ram_data"}, ram_data, {v.data, v.data});
        end else begin
            chk({tag, " ram_we"}, 128'(ram_we), 128'(0));
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            got = ss_ack;
        end
        chk({tag, " ack_latency"}, 128'(lat), 128'(v.exp_lat));
        if (v.rd && !v.wr) chk({tag, " ss_q"}, 128'(ss_q), 128'(v.exp_q));
        repeat (v.hold) @(negedge clk);
        ss_read = 1'b0; ss_write = 1'b0; ss_sel = 1'b0; core_we = 1'b0;
        @(negedge clk);
        chk({tag, " ack_low"}, 128'(ss_ack), 128'(0));
        repeat (2) @(negedge clk);
        chk({tag, " ack_count"}, 128'(ack_cnt - a0), 128'(1));
        chk({tag, " we_count"}, 128'(we_cnt - w0), 128'(v.wr ? 1 : 0));
    endtask

    vec_t vecs [16];
    vec_t post [2];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, w0;
        //          rd wr addr   data                    waddr  be        q                      lat hold
        vecs[0]  = '{0, 1, 32'd7,    64'h1122334455667788, 10'd3,    16'hFF00, 64'h0,                 1, 0};
        vecs[1]  = '{1, 0, 32'd7,    64'h0,                10'd3,    16'h0,    64'h1122334455667788,  3, 0};
        vecs[2]  = '{1, 0, 32'd6,    64'h0,                10'd3,    16'h0,    64'h0,                 3, 0};
        vecs[3]  = '{0, 1, 32'd6,    64'hCAFEBABEDEADBEEF, 10'd3,    16'h00FF, 64'h0,                 1, 0};
        vecs[4]  = '{1, 0, 32'd6,    64'h0,                10'd3,    16'h0,    64'hCAFEBABEDEADBEEF,  3, 0};
        vecs[5]  = '{1, 0, 32'd7,    64'h0,                10'd3,    16'h0,    64'h1122334455667788,  3, 0};
        vecs[6]  = '{0, 1, 32'd2049, 64'h0123456789ABCDEF, 10'd0,    16'hFF00, 64'h0,                 1, 0};
        vecs[7]  = '{1, 0, 32'd1,    64'h0,                10'd0,    16'h0,    64'h0123456789ABCDEF,  3, 0};
        vecs[8]  = '{1, 0, 32'd0,    64'h0,                10'd0,    16'h0,    64'h0,                 3, 0};
        vecs[9]  = '{0, 1, 32'd2047, 64'hFFFF0000FFFF0000, 10'd1023, 16'hFF00, 64'h0,                 1, 0};
        vecs[10] = '{1, 0, 32'd2047, 64'h0,                10'd1023, 16'h0,    64'hFFFF0000FFFF0000,  3, 0};
        vecs[11] = '{1, 1, 32'd6,    64'h0000000000005555, 10'd3,    16'h00FF, 64'h0,                 1, 0};
        vecs[12] = '{1, 0, 32'd6,    64'h0,                10'd3,    16'h0,    64'h0000000000005555,  3, 0};
        vecs[13] = '{1, 0, 32'd7,    64'h0,                10'd3,    16'h0,    64'h1122334455667788,  3, 0};
        vecs[14] = '{0, 1, 32'd10,   64'h0000000000000077, 10'd5,    16'h00FF, 64'h0,                 1, 10};
        vecs[15] = '{1, 0, 32'd10,   64'h0,                10'd5,    16'h0,    64'h0000000000000077,  3, 10};
        post[0]  = '{1, 0, 32'd40,   64'h0,                10'd20,   16'h0,    64'h00A500A500A500A5,  3, 0};
        post[1]  = '{1, 0, 32'd41,   64'h0,                10'd20,   16'h0,    64'h00A500A500A500A5,  3, 0};

        reset = 1'b1;
        ss_sel = 1'b0; ss_read = 1'b0; ss_write = 1'b0; ss_addr = '0; ss_data = '0;
        core_we = 1'b0; core_addr = 10'd5; core_be = 16'h0F0F;
        core_data = 128'h000102030405060708090A0B0C0D0E0F;
        repeat (2) @(negedge clk);
        chk("rst ss_ack", 128'(ss_ack), 128'(0));
        chk("rst ss_q", 128'(ss_q), 128'(0));
        chk("ss_width", 128'(ss_width), 128'(3));
        chk("ss_size", 128'(ss_size), 128'(2048));
        chk("rst core_stall", 128'(core_stall), 128'(0));
        chk("mux ram_addr", 128'(ram_addr), 128'(5));
        chk("mux ram_be", 128'(ram_be), 128'(16'h0F0F));
        chk("mux ram_data", ram_data, 128'h000102030405060708090A0B0C0D0E0F);
        chk("mux ram_we", 128'(ram_we), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Reset while the read is waiting on RAM latency
        a0 = ack_cnt; w0 = we_cnt;
        @(negedge clk);
        ss_sel = 1'b1; ss_read = 1'b1; ss_addr = 32'd7;
        @(negedge clk);
        reset = 1'b1; ss_read = 1'b0;
        #1;
        chk("rst_rd ss_ack", 128'(ss_ack), 128'(0));
        chk("rst_rd ss_q", 128'(ss_q), 128'(0));
        chk("rst_rd stall_hi", 128'(core_stall), 128'(1));
        @(negedge clk);
        ss_sel = 1'b0;
        #1;
        chk("rst_rd stall_lo", 128'(core_stall), 128'(0));
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_rd ack_count", 128'(ack_cnt - a0), 128'(0));
        chk("rst_rd we_count", 128'(we_cnt - w0), 128'(0));
        chk("rst_rd ss_q_after", 128'(ss_q), 128'(0));

        // Savestate deselected mid-read while the core writes
        a0 = ack_cnt;
        @(negedge clk);
        ss_sel = 1'b1; ss_read = 1'b1; ss_addr = 32'd41;
        @(negedge clk);
        ss_sel = 1'b0; core_we = 1'b1; core_addr = 10'd20;
        core_data = {4{32'hA5A5A5A5}}; core_be = 16'h5555;
        #1;
        chk("drop ram_we", 128'(ram_we), 128'(1));
        chk("drop ram_addr", 128'(ram_addr), 128'(20));
        chk("drop ram_be", 128'(ram_be), 128'(16'h5555));
        chk("drop stall", 128'(core_stall), 128'(0));
        @(negedge clk);
        core_we = 1'b0; ss_read = 1'b0;
        chk("drop core_write_landed", mem[20], {4{32'h00A500A5}});
        repeat (3) @(negedge clk);
        chk("drop ack_count", 128'(ack_cnt - a0), 128'(0));
        chk("drop ss_q_kept", 128'(ss_q), 128'(0));

        for (int i = 0; i < 2; i++) run_vec(16 + i, post[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
